// File: rtl/aer_spike_encoder.sv
// AER spike encoder: captures per-neuron spike pulses with a timestamp and
// serialises them through a round-robin arbiter and a first-word-fall-through FIFO.
module aer_spike_encoder #(
  parameter int unsigned N_NEURONS  = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned TS_W       = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic [TS_W-1:0]      aer_ts,
  output logic [7:0]           drop_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);
  localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N_NEURONS);

  logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]      ts_reg_q [N_NEURONS];
  logic [TS_W-1:0]      ts_reg_d [N_NEURONS];
  logic [ADDR_W-1:0]    last_grant_q, last_grant_d;
  logic [7:0]           drop_count_q, drop_count_d;

  logic [ADDR_W-1:0]    addr_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    addr_mem_d [FIFO_DEPTH];
  logic [TS_W-1:0]      ts_mem_q [FIFO_DEPTH];
  logic [TS_W-1:0]      ts_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [ADDR_W-1:0]    rr_start;
  logic [ADDR_W-1:0]    grant_off;
  logic [ADDR_W:0]      grant_sum;
  logic [ADDR_W-1:0]    grant_idx;
  logic [N_NEURONS-1:0] pend_rot;
  logic [N_NEURONS-1:0] grant_vec;
  logic [N_NEURONS-1:0] capture_vec;
  logic [N_NEURONS-1:0] merge_vec;
  logic                 grant_valid;
  logic                 push;
  logic                 pop;
  logic [31:0]          drop_sum;

  // Rotate pending so bit 0 is the first candidate after last_grant, then
  // pick the lowest set bit and map the offset back to a neuron index.
  always_comb begin
    rr_start    = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + ADDR_W'(1);
    pend_rot    = N_NEURONS'({pending_q, pending_q} >> rr_start);
    grant_valid = 1'b0;
    grant_off   = '0;
    if (count_q < FULL_CNT) begin
      for (int unsigned j = 0; j < N_NEURONS; j++) begin
        if (!grant_valid && pend_rot[j]) begin
          grant_valid = 1'b1;
          grant_off   = ADDR_W'(j);
        end
      end
    end
    grant_sum = {1'b0, rr_start} + {1'b0, grant_off};
    if (grant_sum >= N_EXT) begin
      grant_sum = grant_sum - N_EXT;
    end
    grant_idx = grant_sum[ADDR_W-1:0];
    grant_vec = grant_valid ? (N_NEURONS'(1) << grant_idx) : '0;
  end

  always_comb begin
    ts_cnt_d     = ts_cnt_q + TS_W'(1);
    capture_vec  = spike_in & (~pending_q | grant_vec);
    merge_vec    = spike_in & pending_q & ~grant_vec;
    pending_d    = (pending_q & ~grant_vec) | capture_vec;
    last_grant_d = grant_valid ? grant_idx : last_grant_q;
    ts_reg_d     = ts_reg_q;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (capture_vec[i]) begin
        ts_reg_d[i] = ts_cnt_q;
      end
    end
    drop_sum = 32'(drop_count_q);
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      drop_sum = drop_sum + 32'(merge_vec[i]);
    end
    drop_count_d = (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    push       = grant_valid;
    pop        = aer_valid && aer_ready;
    addr_mem_d = addr_mem_q;
    ts_mem_d   = ts_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = grant_idx;
      ts_mem_d[wr_ptr_q]   = ts_reg_q[grant_idx];
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q     <= '0;
      pending_q    <= '0;
      last_grant_q <= LAST_IDX;
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        ts_reg_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        ts_mem_q[i]   <= '0;
      end
    end else begin
      ts_cnt_q     <= ts_cnt_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ts_reg_q     <= ts_reg_d;
      addr_mem_q   <= addr_mem_d;
      ts_mem_q     <= ts_mem_d;
    end
  end

  assign aer_valid  = (count_q != '0);
  assign aer_addr   = addr_mem_q[rd_ptr_q];
  assign aer_ts     = ts_mem_q[rd_ptr_q];
  assign drop_count = drop_count_q;

endmodule
